// File: rtl/leb128_fetch.sv
// LEB128 decoder fetching one byte per ROM access (one-cycle read latency).
// Define LEB128_SIGNED_EN to honour is_signed (sign-extended decodes).
module leb128_fetch #(
    parameter int MEM_DEPTH = 4,
    parameter int MAX_BYTES = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [MEM_DEPTH:0]   start_addr,
    input  logic                 is_signed,
    output logic                 busy,
    output logic                 done,
    output logic [63:0]          value,
    output logic [3:0]           length,
    output logic [MEM_DEPTH:0]   next_addr,
    output logic [1:0]           error,
    output logic [MEM_DEPTH:0]   mem_addr,
    output logic [3:0]           mem_extra,
    input  logic [7:0]           mem_data,
    input  logic                 mem_error
);

    localparam int AW = MEM_DEPTH + 1;

    typedef enum logic [1:0] {IDLE, REQ, ACC, DONE} state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [AW-1:0]  base_q, base_d;
    logic [63:0]    acc_q, acc_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           sgn_q, sgn_d;
    logic [63:0]    value_q, value_d;
    logic [3:0]     len_q, len_d;
    logic [AW-1:0]  nxt_q, nxt_d;
    logic [1:0]     err_q, err_d;

    logic [6:0]     shamt;
    logic [63:0]    acc_new;
    logic [63:0]    ext_mask;
    logic           last_byte;

    // Payload of byte n lands at bit 7n; bits shifted past 63 fall off.
    assign shamt     = {3'd0, cnt_q} * 7'd7;
    assign acc_new   = acc_q | ({57'd0, mem_data[6:0]} << shamt);
    assign ext_mask  = ~64'd0 << (shamt + 7'd7);
    assign last_byte = (cnt_q == 4'(MAX_BYTES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = REQ;
            REQ:  state_d = ACC;
            ACC: begin
                if (mem_error || !mem_data[7] || last_byte) begin
                    state_d = DONE;
                end else begin
                    state_d = REQ;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    always_comb begin
        addr_d  = addr_q;
        base_d  = base_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        value_d = value_q;
        len_d   = len_q;
        nxt_d   = nxt_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d = start_addr;
                    base_d = start_addr;
                    acc_d  = '0;
                    cnt_d  = '0;
`ifdef LEB128_SIGNED_EN
                    sgn_d  = is_signed;
`else
                    sgn_d  = is_signed & 1'b0;
`endif
                end
            end
            ACC: begin
                if (mem_error) begin
                    value_d = acc_q;
                    len_d   = cnt_q;
                    nxt_d   = base_q + AW'(cnt_q);
                    err_d   = 2'd1;
                end else if (!mem_data[7]) begin
                    value_d = (sgn_q && mem_data[6]) ? (acc_new | ext_mask)
                                                     : acc_new;
                    len_d   = cnt_q + 4'd1;
                    nxt_d   = base_q + AW'(cnt_q) + AW'(1);
                    err_d   = 2'd0;
                end else if (last_byte) begin
                    value_d = acc_new;
                    len_d   = 4'(MAX_BYTES);
                    nxt_d   = base_q + AW'(MAX_BYTES);
                    err_d   = 2'd2;
                end else begin
                    acc_d  = acc_new;
                    cnt_d  = cnt_q + 4'd1;
                    addr_d = addr_q + AW'(1);
                end
            end
            default: ;
        endcase
    end

    // addr_q only moves on edges entering REQ, so mem_addr holds elsewhere.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            base_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            value_q <= '0;
            len_q   <= '0;
            nxt_q   <= '0;
            err_q   <= '0;
        end else begin
            addr_q  <= addr_d;
            base_q  <= base_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            value_q <= value_d;
            len_q   <= len_d;
            nxt_q   <= nxt_d;
            err_q   <= err_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_extra = 4'd0;
    assign value     = value_q;
    assign length    = len_q;
    assign next_addr = nxt_q;
    assign error     = err_q;

endmodule

// File: tb/tb_leb128_fetch.sv
// Bench for leb128_fetch: ROM model, reference decoder, per-cycle compare.
// Signed cases run only when LEB128_SIGNED_EN is defined.
module tb_leb128_fetch;

    localparam int MD    = 4;
    localparam int AW    = MD + 1;
    localparam int DEPTH = 1 << AW;
    localparam int MAXB  = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic          is_signed = 1'b0;
    logic          busy, done;
    logic [63:0]   value;
    logic [3:0]    length;
    logic [AW-1:0] next_addr;
    logic [1:0]    error;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_extra;
    logic [7:0]    mem_data = 8'd0;
    logic          mem_error = 1'b0;

    logic [7:0]    rom [DEPTH];
    int            ub = DEPTH - 1;

    int            checks = 0;
    int            errors = 0;
    int            edge_n = 0;

    bit            active = 1'b0;
    int            t_start = 0;
    int            t_done = 0;
    logic [63:0]   prev_v = '0, cur_v = '0;
    logic [3:0]    prev_l = '0, cur_l = '0;
    logic [AW-1:0] prev_n = '0, cur_n = '0;
    logic [1:0]    prev_e = '0, cur_e = '0;

    logic [63:0]   mv;
    logic [3:0]    ml;
    logic [1:0]    me;
    int            lat;

    leb128_fetch #(.MEM_DEPTH(MD), .MAX_BYTES(MAXB)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .is_signed  (is_signed),
        .busy       (busy),
        .done       (done),
        .value      (value),
        .length     (length),
        .next_addr  (next_addr),
        .error      (error),
        .mem_addr   (mem_addr),
        .mem_extra  (mem_extra),
        .mem_data   (mem_data),
        .mem_error  (mem_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n++;

    // ROM with one-cycle read latency; addresses above ub report an error
    always @(posedge clk) begin
        mem_data  <= rom[mem_addr];
        mem_error <= (int'(mem_addr) > ub);
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference decoder straight from the LEB128 rules
    function automatic void model(input logic [AW-1:0] sa, input bit sg,
                                  output logic [63:0] v, output logic [3:0] len,
                                  output logic [1:0] err, output int reads);
        int a;
        logic [7:0] b;
        v = '0;
        len = '0;
        err = 2'd0;
        reads = 0;
        for (int n = 0; n < MAXB; n++) begin
            a = (int'(sa) + n) % DEPTH;
            reads = n + 1;
            if (a > ub) begin
                err = 2'd1;
                len = 4'(n);
                return;
            end
            b = rom[a];
            if (7 * n < 64) v |= 64'(b[6:0]) << (7 * n);
            if (!b[7]) begin
                len = 4'(n + 1);
                if (sg && b[6] && 7 * (n + 1) < 64)
                    v |= ~64'd0 << (7 * (n + 1));
                return;
            end
        end
        err = 2'd2;
        len = 4'(MAXB);
    endfunction

    task automatic arm(input logic [AW-1:0] sa, input bit sg,
                       output int lt);
        logic [63:0] v;
        logic [3:0] l;
        logic [1:0] e;
        int reads;
        bit msg;
`ifdef LEB128_SIGNED_EN
        msg = sg;
`else
        msg = 1'b0;
`endif
        model(sa, msg, v, l, e, reads);
        prev_v = cur_v; prev_l = cur_l; prev_n = cur_n; prev_e = cur_e;
        cur_v = v; cur_l = l; cur_e = e;
        cur_n = sa + AW'(l);
        t_start = edge_n + 1;
        t_done = t_start + 2 * reads;
        active = 1'b1;
        lt = 2 * reads;
        start = 1'b1;
        start_addr = sa;
        is_signed = sg;
    endtask

    // Full decode; start is toggled randomly while busy and in DONE
    task automatic run(input logic [AW-1:0] sa, input bit sg, output int lt);
        @(posedge clk);
        #2;
        arm(sa, sg, lt);
        repeat (lt + 1) begin
            @(posedge clk);
            #2;
            start = 1'($urandom);
            start_addr = AW'($urandom);
            is_signed = 1'($urandom);
        end
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    always @(negedge clk) begin
        bit eb, ed, old;
        if (!reset) begin
            eb = active && edge_n >= t_start && edge_n <= t_done;
            ed = active && edge_n == t_done;
            old = active && edge_n < t_done;
            chk("busy", busy, eb);
            chk("done", done, ed);
            chk("mem_extra", mem_extra, 0);
            if (ed || !eb) begin
                chk("value", value, old ? prev_v : cur_v);
                chk("length", length, old ? prev_l : cur_l);
                chk("next_addr", next_addr, old ? prev_n : cur_n);
                chk("error", error, old ? prev_e : cur_e);
            end
        end
    end

    task automatic chk_reset_outputs();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_value", value, 0);
        chk("rst_length", length, 0);
        chk("rst_next_addr", next_addr, 0);
        chk("rst_error", error, 0);
        chk("rst_mem_addr", mem_addr, 0);
    endtask

    task automatic clear_model();
        active = 1'b0;
        prev_v = '0; prev_l = '0; prev_n = '0; prev_e = '0;
        cur_v = '0; cur_l = '0; cur_n = '0; cur_e = '0;
    endtask

    initial begin
        logic [AW-1:0] sa;
        int len;
        for (int i = 0; i < DEPTH; i++) rom[i] = 8'h00;
        #1 reset = 1'b1;
        #1 chk_reset_outputs();
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        rom[0] = 8'h05;
        run(0, 1'b0, lat);
        chk("p029_value", cur_v, 64'd5);
        chk("p029_length", cur_l, 1);
        chk("p029_next", cur_n, 1);
        chk("p029_lat", lat, 2);

        rom[2] = 8'hE5; rom[3] = 8'h8E; rom[4] = 8'h26;
        run(2, 1'b0, lat);
        chk("p030_value", cur_v, 64'd624485);
        chk("p030_length", cur_l, 3);
        chk("p030_next", cur_n, 5);
        chk("p030_lat", lat, 6);

`ifdef LEB128_SIGNED_EN
        rom[8] = 8'hC0; rom[9] = 8'hBB; rom[10] = 8'h78;
        run(8, 1'b1, lat);
        chk("p031_value", cur_v, 64'hFFFF_FFFF_FFFE_1DC0);
        rom[12] = 8'h7F;
        run(12, 1'b1, lat);
        chk("p032_value", cur_v, ~64'd0);
        chk("p032_length", cur_l, 1);
`endif

        for (int i = 0; i < 11; i++) rom[i] = 8'h80;
        run(0, 1'b0, lat);
        chk("p033_error", cur_e, 2);
        chk("p033_length", cur_l, 10);
        chk("p033_lat", lat, 20);

        ub = 3;
        for (int i = 1; i < 5; i++) rom[i] = 8'h80;
        run(1, 1'b0, lat);
        chk("p034_error", cur_e, 1);
        chk("p034_length", cur_l, 3);
        ub = DEPTH - 1;

        rom[2] = 8'hE5; rom[3] = 8'h8E; rom[4] = 8'h26;
        @(posedge clk);
        #2 arm(2, 1'b0, lat);
        @(posedge clk);
        #2 start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        clear_model();
        reset = 1'b1;
        #1 chk_reset_outputs();
        @(posedge clk);
        #2 reset = 1'b0;
        run(2, 1'b0, lat);
        chk("p035_value", cur_v, 64'd624485);

        for (int r = 0; r < 200; r++) begin
            if ($urandom_range(0, 9) == 0)
                for (int i = 0; i < DEPTH; i++) rom[i] = 8'($urandom);
            ub = ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH - 1)
                                             : DEPTH - 1;
            sa = AW'($urandom);
            len = $urandom_range(1, 12);
            for (int j = 0; j < len; j++)
                rom[(int'(sa) + j) % DEPTH] = {(j < len - 1), 7'($urandom)};
            run(sa, 1'($urandom), lat);
        end

        repeat (3) @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
